// File: rtl/ifetch_buf.sv
// -----------------------------------------------------------------------------
// ifetch_buf -- instruction fetch buffer in front of the decoder.
//
// Holds the fetch PC and reads 32-bit words from instruction memory over a
// single-outstanding req/ack handshake. Fetched {instr, pc} pairs are queued in
// a small FIFO and handed downstream under valid/ready. A redirect from decode
// (get_npc/npc) flushes the FIFO and restarts fetch at the new PC. A request
// that is still in flight when the redirect arrives is completed and its data
// is thrown away.
//
// Parameters
//   DEPTH     FIFO entries, power of two in 2..16
//   RESET_PC  fetch PC loaded at reset
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous reset, active low
//   get_npc      in   one-cycle redirect strobe from decode
//   npc          in   redirect target (bits [1:0] ignored)
//   mem_req      out  instruction memory read request
//   mem_addr     out  word address of the request
//   mem_ack      in   one-cycle ack, mem_rdata valid in the same cycle
//   mem_rdata    in   instruction word
//   instr_valid  out  head word valid
//   instr        out  head instruction word
//   instr_pc     out  PC of the head word
//   instr_ready  in   decoder accepts the head word
//
// Configuration macro
//   IFB_BYPASS_EN  when defined, an accepted ack that finds the FIFO empty is
//                  presented on instr/instr_pc in the same cycle, and is not
//                  queued if the decoder takes it. When undefined, the outputs
//                  come only from FIFO registers.
// -----------------------------------------------------------------------------
module ifetch_buf #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        get_npc,
    input  logic [31:0] npc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int unsigned     PTR_W = $clog2(DEPTH);
    localparam int unsigned     CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DROP
    } state_t;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    state_t             state;
    logic [31:0]        fetch_pc;
    entry_t             fifo_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               ack_ok;
    logic               ack_take;
    logic               fifo_valid;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   count_next;
    logic [31:0]        npc_al;
    logic [31:0]        pc_inc;
    logic [31:0]        restart_pc;
    entry_t             head;

    assign npc_al     = npc & 32'hFFFF_FFFC;
    assign pc_inc     = fetch_pc + 32'd4;
    // Address to (re)start fetching from this cycle; a same-cycle redirect wins.
    assign restart_pc = get_npc ? npc_al : fetch_pc;

    // An ack only counts while a request is actually outstanding.
    assign ack_ok     = mem_req & mem_ack;
    // Only a normal fetch in REQ keeps its data; redirects and DROP discard it.
    assign ack_take   = ack_ok & ~get_npc & (state == S_REQ);
    assign fifo_valid = (count != '0);
    assign head       = fifo_q[rd_ptr];
    // A redirect suppresses the pop: the head is being flushed, not consumed.
    assign pop        = fifo_valid & instr_ready & ~get_npc;

`ifdef IFB_BYPASS_EN
    logic bypass;

    assign bypass      = ack_take & ~fifo_valid;
    assign instr_valid = fifo_valid | bypass;
    assign instr       = bypass ? mem_rdata : head.word;
    assign instr_pc    = bypass ? fetch_pc  : head.pc;
    // A bypassed word the decoder takes right away never enters the FIFO.
    assign push        = ack_take & ~(bypass & instr_ready);
`else
    assign instr_valid = fifo_valid;
    assign instr       = head.word;
    assign instr_pc    = head.pc;
    assign push        = ack_take;
`endif

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        count_next = count;
        if (get_npc) begin
            count_next = '0;
        end else begin
            count_next = count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage and pointers. The FSM never requests while full, so a push
    // always has room.
    // NOTE: the storage is reset so instr/instr_pc read as zero out of reset;
    // at these depths the extra reset fan-out is negligible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (get_npc) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (push) begin
                    fifo_q[wr_ptr] <= '{word: mem_rdata, pc: fetch_pc};
                    wr_ptr         <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Fetch FSM with registered request outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
        end else begin
            unique case (state)
                S_IDLE: begin
                    fetch_pc <= restart_pc;
                    if (count_next < FULL) begin
                        state    <= S_REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= restart_pc;
                    end
                end

                S_REQ: begin
                    if (get_npc && ack_ok) begin
                        // Request completed under the redirect: reissue at npc.
                        fetch_pc <= npc_al;
                        mem_addr <= npc_al;
                    end else if (get_npc) begin
                        // Request still in flight: let it finish, discard its data.
                        fetch_pc <= npc_al;
                        state    <= S_DROP;
                    end else if (ack_ok) begin
                        fetch_pc <= pc_inc;
                        mem_addr <= pc_inc;
                        if (count_next >= FULL) begin
                            state   <= S_IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end

                S_DROP: begin
                    fetch_pc <= restart_pc;
                    if (ack_ok) begin
                        state    <= S_REQ;
                        mem_addr <= restart_pc;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_buf.sv
// -----------------------------------------------------------------------------
// tb_ifetch_buf -- self-checking bench for ifetch_buf (DEPTH=4, RESET_PC=0x100).
//
// Instruction memory is modelled as a fixed function of the address, so every
// word the decoder receives can be checked against its PC. The reference model
// is the in-order stream of PCs the decoder should see: it starts at RESET_PC,
// advances by 4 per accepted word and jumps to npc on every redirect. Directed
// tasks cover reset, streaming latency, fill/drain, the two redirect cases,
// address wrap, simultaneous push/pop and mid-request reset; a random phase
// then mixes all of it.
// -----------------------------------------------------------------------------
module tb_ifetch_buf;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        get_npc = 1'b0;
    logic [31:0] npc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    ifetch_buf #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .get_npc     (get_npc),
        .npc         (npc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          pops = 0;
    logic [31:0] exp_pc = RESET_PC;
    bit          prev_pending = 1'b0;
    logic [31:0] prev_addr = '0;

    // Observations of the last cycle driven by step().
    logic        obs_valid, obs_req, obs_ack;
    logic [31:0] obs_pc, obs_instr, obs_addr;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
    endfunction

    // One clock cycle, entered and left just after a falling edge.
    // Drives inputs, samples outputs 1 ns later, updates the reference stream.
    task automatic step(input logic g, input logic [31:0] nv, input logic rdy,
                        input logic ack_en);
        get_npc     = g;
        npc         = nv;
        instr_ready = rdy;
        mem_ack     = ack_en & mem_req;
        mem_rdata   = mem_ack ? mem_fn(mem_addr) : $urandom;
        #1;
        obs_valid = instr_valid;
        obs_pc    = instr_pc;
        obs_instr = instr;
        obs_req   = mem_req;
        obs_addr  = mem_addr;
        obs_ack   = mem_ack;
        if (prev_pending) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin
                failures++;
                $display("FAIL addr_stable: req=%b addr=%h, required req=1 addr=%h",
                         mem_req, mem_addr, prev_addr);
            end
        end
        checks++;
        if (mem_addr[1:0] !== 2'b00) begin
            failures++;
            $display("FAIL addr_align: addr=%h has nonzero low bits", mem_addr);
        end
        if (instr_valid === 1'b1 && rdy && !g) begin
            checks++;
            if (instr_pc !== exp_pc || instr !== mem_fn(exp_pc)) begin
                failures++;
                $display("FAIL pop_order: pc=%h instr=%h, required pc=%h instr=%h",
                         instr_pc, instr, exp_pc, mem_fn(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (g) exp_pc = nv & 32'hFFFF_FFFC;
        prev_pending = mem_req & ~mem_ack;
        prev_addr    = mem_addr;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        get_npc     = 1'b0;
        npc         = '0;
        mem_ack     = 1'b0;
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n        = 1'b1;
        exp_pc       = RESET_PC;
        prev_pending = 1'b0;
    endtask

    // Bounded wait (no acks) for a request to appear.
    task automatic wait_req(input logic rdy);
        int n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            step(1'b0, '0, rdy, 1'b0);
            n++;
        end
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL wait_req: no request within 20 cycles, req=%b", mem_req);
        end
    endtask

    // Ack everything until a request for addr is pending (not yet acked).
    task automatic wait_for_addr(input logic [31:0] addr, input logic rdy);
        int n = 0;
        while (!(mem_req === 1'b1 && mem_addr === addr) && n < 20) begin
            step(1'b0, '0, rdy, 1'b1);
            n++;
        end
        checks++;
        if (!(mem_req === 1'b1 && mem_addr === addr)) begin
            failures++;
            $display("FAIL wait_addr: req=%b addr=%h, required req=1 addr=%h",
                     mem_req, mem_addr, addr);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        get_npc     = 1'b0;
        mem_ack     = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== RESET_PC || instr_valid !== 1'b0 ||
            instr !== 32'h0 || instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: req=%b addr=%h valid=%b instr=%h pc=%h, required 0 %h 0 0 0",
                     mem_req, mem_addr, instr_valid, instr, instr_pc, RESET_PC);
        end
        @(negedge clk);
        rst_n        = 1'b1;
        exp_pc       = RESET_PC;
        prev_pending = 1'b0;
        step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (obs_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: req=%b in first cycle, required 0", obs_req);
        end
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
            failures++;
            $display("FAIL reset_first_req: req=%b addr=%h, required 1 %h",
                     mem_req, mem_addr, RESET_PC);
        end
    endtask

    // Ack every cycle with ready=1: addresses climb by 4, instr_pc trails by
    // one cycle (same cycle with bypass).
    task automatic test_stream();
        apply_reset();
        wait_req(1'b1);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (mem_addr !== RESET_PC + 32'(4 * k)) begin
                failures++;
                $display("FAIL stream_addr k=%0d: addr=%h, required %h",
                         k, mem_addr, RESET_PC + 32'(4 * k));
            end
            step(1'b0, '0, 1'b1, 1'b1);
            checks++;
`ifdef IFB_BYPASS_EN
            if (obs_valid !== 1'b1 || obs_pc !== RESET_PC + 32'(4 * k)) begin
                failures++;
                $display("FAIL stream_pc k=%0d: valid=%b pc=%h, required 1 %h",
                         k, obs_valid, obs_pc, RESET_PC + 32'(4 * k));
            end
`else
            if (k == 0) begin
                if (obs_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_pc k=0: valid=%b, required 0", obs_valid);
                end
            end else if (obs_valid !== 1'b1 || obs_pc !== RESET_PC + 32'(4 * (k - 1))) begin
                failures++;
                $display("FAIL stream_pc k=%0d: valid=%b pc=%h, required 1 %h",
                         k, obs_valid, obs_pc, RESET_PC + 32'(4 * (k - 1)));
            end
`endif
        end
    endtask

    // ready=0: exactly DEPTH words accepted, then drain in order and resume.
    task automatic test_fill_drain();
        int acks = 0;
        int p0;
        bit seen = 1'b0;
        logic [31:0] first_addr = '0;
        apply_reset();
        repeat (12) begin
            step(1'b0, '0, 1'b0, 1'b1);
            if (obs_ack) acks++;
        end
        checks++;
        if (acks != int'(DEPTH)) begin
            failures++;
            $display("FAIL fill_acks: accepted=%0d, required %0d", acks, DEPTH);
        end
        checks++;
        if (obs_req !== 1'b0 || obs_valid !== 1'b1 || obs_pc !== RESET_PC ||
            obs_instr !== mem_fn(RESET_PC)) begin
            failures++;
            $display("FAIL fill_state: req=%b valid=%b pc=%h instr=%h, required 0 1 %h %h",
                     obs_req, obs_valid, obs_pc, obs_instr, RESET_PC, mem_fn(RESET_PC));
        end
        p0 = pops;
        repeat (8) begin
            if (!seen && mem_req === 1'b1) begin
                seen       = 1'b1;
                first_addr = mem_addr;
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        checks++;
        if (pops - p0 != int'(DEPTH)) begin
            failures++;
            $display("FAIL drain_count: popped=%0d, required %0d", pops - p0, DEPTH);
        end
        checks++;
        if (!seen || first_addr !== RESET_PC + 32'h10) begin
            failures++;
            $display("FAIL drain_resume: seen=%b addr=%h, required 1 %h",
                     seen, first_addr, RESET_PC + 32'h10);
        end
    endtask

    // Redirect while the request at 0x108 is in flight; ack arrives 3 cycles later.
    task automatic test_redirect_pending();
        apply_reset();
        wait_for_addr(32'h108, 1'b1);
        step(1'b1, 32'h2002, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h108) begin
            failures++;
            $display("FAIL redir_drop_hold: valid=%b req=%b addr=%h, required 0 1 00000108",
                     obs_valid, obs_req, obs_addr);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h2000) begin
            failures++;
            $display("FAIL redir_new_addr: req=%b addr=%h, required 1 00002000",
                     mem_req, mem_addr);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (obs_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_dropped: valid=%b pc=%h, required valid 0", obs_valid, obs_pc);
        end
        repeat (6) step(1'b0, '0, 1'b1, 1'b1);
    endtask

    // Redirect and ack in the same cycle: data discarded, reissue at npc.
    task automatic test_redirect_ack();
        apply_reset();
        wait_for_addr(32'h104, 1'b1);
        step(1'b1, 32'h400, 1'b1, 1'b1);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin
            failures++;
            $display("FAIL redir_ack_addr: req=%b addr=%h, required 1 00000400",
                     mem_req, mem_addr);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (obs_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_ack_flush: valid=%b pc=%h, required valid 0", obs_valid, obs_pc);
        end
        repeat (5) step(1'b0, '0, 1'b1, 1'b1);
    endtask

    // PC wrap at 2^32, npc low bits ignored, and push+pop holding count at 2.
    task automatic test_wrap_and_pushpop();
        int acks = 0;
        apply_reset();
        wait_req(1'b1);
        step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        checks++;
        if (mem_addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_npc_align: addr=%h, required fffffffc", mem_addr);
        end
        step(1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_addr: req=%b addr=%h, required 1 00000000", mem_req, mem_addr);
        end
        repeat (3) step(1'b0, '0, 1'b1, 1'b1);

        apply_reset();
        wait_req(1'b0);
        repeat (2) step(1'b0, '0, 1'b0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b1, 1'b1);
        repeat (10) begin
            step(1'b0, '0, 1'b0, 1'b1);
            if (obs_ack) acks++;
        end
        checks++;
        if (acks != int'(DEPTH) - 2) begin
            failures++;
            $display("FAIL pushpop_count: room=%0d, required %0d", acks, DEPTH - 2);
        end
        checks++;
        if (obs_req !== 1'b0 || obs_valid !== 1'b1 || obs_pc !== exp_pc) begin
            failures++;
            $display("FAIL pushpop_head: req=%b valid=%b pc=%h, required 0 1 %h",
                     obs_req, obs_valid, obs_pc, exp_pc);
        end
    endtask

    // Asynchronous reset with a request pending and 3 entries queued.
    task automatic test_reset_mid();
        apply_reset();
        wait_req(1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b1);
        #2;
        rst_n   = 1'b0;
        mem_ack = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: req=%b valid=%b, required 0 0", mem_req, instr_valid);
        end
        @(negedge clk);
        rst_n        = 1'b1;
        exp_pc       = RESET_PC;
        prev_pending = 1'b0;
        wait_req(1'b1);
        checks++;
        if (mem_addr !== RESET_PC) begin
            failures++;
            $display("FAIL reset_restart: addr=%h, required %h", mem_addr, RESET_PC);
        end
        repeat (6) step(1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        int p0;
        apply_reset();
        p0 = pops;
        repeat (3000) begin
            step($urandom_range(0, 99) < 3, $urandom,
                 $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 50);
        end
        checks++;
        if (pops - p0 < 100) begin
            failures++;
            $display("FAIL random_progress: popped=%0d, required at least 100", pops - p0);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_drain();
        test_redirect_pending();
        test_redirect_ack();
        test_wrap_and_pushpop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
